weight_bank_controller: RTL and testbench

WEIGHT_BANK_CONTROLLER -- requirements
Module: weight_bank_controller

---
 rtl/weight_bank_controller_if.sv | 32 +++
 rtl/weight_bank_controller.sv | 85 ++++++++
 tb/tb_weight_bank_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/weight_bank_controller_if.sv
// weight_bank_controller_if: producer, consumer and accumulator signals of the weight bank controller
interface weight_bank_controller_if #(
    parameter int NUM_BANKS = 2,
    parameter int BSEL_W = 1,
    parameter int ADDR_W = 4
);
    logic flush;
    logic wr_valid;
    logic wr_ready;
    logic [NUM_BANKS-1:0] wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BSEL_W-1:0] wr_bank;
    logic run;
    logic reuse;
    logic rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [BSEL_W-1:0] rd_bank;
    logic acc_en;
    logic acc_clear;
    logic acc_last;
    logic [NUM_BANKS-1:0] bank_full;
    modport master (
        output flush, wr_valid, run, reuse,
        input wr_ready, wr_en, wr_addr, wr_bank, rd_en, rd_addr, rd_bank,
        input acc_en, acc_clear, acc_last, bank_full
    );
    modport slave (
        input flush, wr_valid, run, reuse,
        output wr_ready, wr_en, wr_addr, wr_bank, rd_en, rd_addr, rd_bank,
        output acc_en, acc_clear, acc_last, bank_full
    );
endinterface

// File: rtl/weight_bank_controller.sv
// weight_bank_controller: round-robin weight SRAM banks filled by a producer and streamed into an accumulator
module weight_bank_controller #(
    parameter int NUM_BANKS = 2,
    parameter int BSEL_W = 1,
    parameter int ADDR_W = 4,
    parameter int DEPTH = 16
) (
    input logic clk,
    input logic reset,
    weight_bank_controller_if.slave bus
);
    typedef enum logic {IDLE, READ} state_t;
    state_t state, state_next;
    logic [NUM_BANKS-1:0] bank_full, wr_onehot, rd_onehot;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [BSEL_W-1:0] wr_bank, rd_bank, wr_bank_next, rd_bank_next;
    logic acc_en, acc_clear, acc_last;
    logic wr_fire, wr_last, rd_fire, rd_last, rd_release;

    assign bus.wr_ready = ~bank_full[wr_bank] & ~bus.flush;
    assign wr_fire = bus.wr_valid & bus.wr_ready & ~reset;
    assign wr_last = wr_ptr == ADDR_W'(DEPTH - 1);
    assign rd_fire = (state == READ) & bus.run;
    assign rd_last = rd_ptr == ADDR_W'(DEPTH - 1);
    assign rd_release = rd_fire & rd_last & ~bus.reuse;
    assign wr_onehot = NUM_BANKS'(1) << wr_bank;
    assign rd_onehot = NUM_BANKS'(1) << rd_bank;
    assign wr_bank_next = wr_bank == BSEL_W'(NUM_BANKS - 1) ? '0 : wr_bank + BSEL_W'(1);
    assign rd_bank_next = rd_bank == BSEL_W'(NUM_BANKS - 1) ? '0 : rd_bank + BSEL_W'(1);

    assign bus.wr_en = wr_fire ? wr_onehot : '0;
    assign bus.wr_addr = wr_ptr;
    assign bus.wr_bank = wr_bank;
    assign bus.rd_en = rd_fire;
    assign bus.rd_addr = rd_ptr;
    assign bus.rd_bank = rd_bank;
    assign bus.acc_en = acc_en;
    assign bus.acc_clear = acc_clear;
    assign bus.acc_last = acc_last;
    assign bus.bank_full = bank_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= bus.flush ? IDLE : state_next;
    end

    // leaving READ for one cycle after every pass gives the bubble between passes
    always_comb begin
        state_next = state == IDLE ? (bus.run & bank_full[rd_bank] ? READ : IDLE)
                                   : (rd_fire & rd_last ? IDLE : READ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_full <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_bank <= '0;
            rd_bank <= '0;
            acc_en <= 1'b0;
            acc_clear <= 1'b0;
            acc_last <= 1'b0;
        end else if (bus.flush) begin
            bank_full <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_bank <= '0;
            rd_bank <= '0;
            acc_en <= 1'b0;
            acc_clear <= 1'b0;
            acc_last <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr <= wr_last ? '0 : wr_ptr + ADDR_W'(1);
            if (wr_fire & wr_last) wr_bank <= wr_bank_next;
            if (rd_fire) rd_ptr <= rd_last ? '0 : rd_ptr + ADDR_W'(1);
            if (rd_release) rd_bank <= rd_bank_next;
            bank_full <= (bank_full | (wr_fire & wr_last ? wr_onehot : '0))
                         & ~(rd_release ? rd_onehot : '0);
            // SRAM data arrives one cycle after rd_en, so the accumulator controls trail by one
            acc_en <= rd_fire;
            acc_clear <= rd_fire & (rd_ptr == '0);
            acc_last <= rd_fire & rd_last;
        end
    end
endmodule

// File: tb/tb_weight_bank_controller.sv
// tb_weight_bank_controller: directed checks of fill, read passes, backpressure, pause, reuse, flush and reset
module tb_weight_bank_controller;
    localparam int NB = 2;
    localparam int BW = 1;
    localparam int AW = 4;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    weight_bank_controller_if #(.NUM_BANKS(NB), .BSEL_W(BW), .ADDR_W(AW)) bus ();

    weight_bank_controller #(.NUM_BANKS(NB), .BSEL_W(BW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        bus.flush = 0; bus.wr_valid = 0; bus.run = 0; bus.reuse = 0;
        reset = 1;
        cyc;
        cyc;
        reset = 0;
    endtask

    task automatic fill_bank;
        bus.wr_valid = 1;
        repeat (DP) cyc;
        bus.wr_valid = 0;
    endtask

    task automatic test_reset;
        apply_reset;
        reset = 1;
        #1;
        checks++;
        if ({bus.wr_en, bus.rd_en, bus.acc_en, bus.acc_clear, bus.acc_last} !== 5'b0)
            begin errors++; $display("FAIL reset_strobes: got %b expected 00000", {bus.wr_en, bus.rd_en, bus.acc_en, bus.acc_clear, bus.acc_last}); end
        checks++;
        if ({bus.wr_addr, bus.rd_addr} !== 8'h00)
            begin errors++; $display("FAIL reset_addr: got %h expected 00", {bus.wr_addr, bus.rd_addr}); end
        checks++;
        if ({bus.bank_full, bus.wr_bank, bus.rd_bank, bus.wr_ready} !== 5'b00001)
            begin errors++; $display("FAIL reset_state: got %b expected 00001", {bus.bank_full, bus.wr_bank, bus.rd_bank, bus.wr_ready}); end
        reset = 0;
        cyc;
        checks++;
        if ({bus.bank_full, bus.wr_ready, bus.rd_en, bus.wr_addr} !== 8'b00100000)
            begin errors++; $display("FAIL post_reset: got %b expected 00100000", {bus.bank_full, bus.wr_ready, bus.rd_en, bus.wr_addr}); end
    endtask

    task automatic test_fill;
        bus.wr_valid = 1;
        for (int i = 0; i < DP; i++) begin
            #1;
            checks++;
            if ({bus.wr_ready, bus.wr_en, bus.wr_addr, bus.wr_bank} !== {1'b1, 2'b01, 4'(i), 1'b0})
                begin errors++; $display("FAIL fill_word%0d: got rdy/en/addr/bank %b/%b/%0d/%0d expected 1/01/%0d/0", i, bus.wr_ready, bus.wr_en, bus.wr_addr, bus.wr_bank, i); end
            cyc;
        end
        bus.wr_valid = 0;
        #1;
        checks++;
        if ({bus.bank_full, bus.wr_bank, bus.wr_en, bus.wr_addr} !== {2'b01, 1'b1, 2'b00, 4'd0})
            begin errors++; $display("FAIL fill_done: got full/bank/en/addr %b/%0d/%b/%0d expected 01/1/00/0", bus.bank_full, bus.wr_bank, bus.wr_en, bus.wr_addr); end
    endtask

    task automatic test_read_pass;
        bus.run = 1; bus.reuse = 0;
        for (int c = 0; c < 6; c++) begin
            logic er;
            logic [3:0] ea;
            logic [2:0] eacc;
            er = (c >= 1 && c <= 4);
            ea = er ? 4'(c - 1) : 4'd0;
            eacc = {c >= 2 && c <= 5, c == 2, c == 5};
            #1;
            checks++;
            if ({bus.rd_en, bus.rd_addr, bus.rd_bank} !== {er, ea, c == 5})
                begin errors++; $display("FAIL pass_rd_c%0d: got en/addr/bank %b/%0d/%0d expected %b/%0d/%0d", c, bus.rd_en, bus.rd_addr, bus.rd_bank, er, ea, c == 5); end
            checks++;
            if ({bus.acc_en, bus.acc_clear, bus.acc_last} !== eacc)
                begin errors++; $display("FAIL pass_acc_c%0d: got %b expected %b", c, {bus.acc_en, bus.acc_clear, bus.acc_last}, eacc); end
            cyc;
        end
        bus.run = 0;
        #1;
        checks++;
        if ({bus.bank_full, bus.rd_bank, bus.rd_en} !== 4'b0010)
            begin errors++; $display("FAIL pass_done: got full/bank/en %b/%0d/%b expected 00/1/0", bus.bank_full, bus.rd_bank, bus.rd_en); end
    endtask

    task automatic test_backpressure;
        apply_reset;
        bus.wr_valid = 1;
        for (int i = 0; i < 2 * DP; i++) begin
            #1;
            checks++;
            if ({bus.wr_en, bus.wr_addr} !== {(i < DP) ? 2'b01 : 2'b10, 4'(i % DP)})
                begin errors++; $display("FAIL bp_fill%0d: got en/addr %b/%0d expected %b/%0d", i, bus.wr_en, bus.wr_addr, (i < DP) ? 2'b01 : 2'b10, i % DP); end
            cyc;
        end
        bus.run = 1;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) bus.run = 0;
            #1;
            checks++;
            if (c < 5 && {bus.wr_ready, bus.wr_en, bus.wr_addr, bus.bank_full[0]} !== {1'b0, 2'b00, 4'd0, 1'b1})
                begin errors++; $display("FAIL bp_stall_c%0d: got rdy/en/addr/full0 %b/%b/%0d/%b expected 0/00/0/1", c, bus.wr_ready, bus.wr_en, bus.wr_addr, bus.bank_full[0]); end
            if (c == 5 && {bus.wr_ready, bus.wr_en, bus.wr_addr, bus.wr_bank} !== {1'b1, 2'b01, 4'd0, 1'b0})
                begin errors++; $display("FAIL bp_accept: got rdy/en/addr/bank %b/%b/%0d/%0d expected 1/01/0/0", bus.wr_ready, bus.wr_en, bus.wr_addr, bus.wr_bank); end
            cyc;
        end
        bus.wr_valid = 0;
        #1;
        checks++;
        if ({bus.wr_addr, bus.bank_full, bus.rd_bank} !== {4'd1, 2'b10, 1'b1})
            begin errors++; $display("FAIL bp_after: got addr/full/rd_bank %0d/%b/%0d expected 1/10/1", bus.wr_addr, bus.bank_full, bus.rd_bank); end
    endtask

    task automatic test_pause;
        logic [9:0] run_pat;
        logic [9:0] en_pat;
        int addr_tab [10];
        int n_en, n_clr, n_last;
        run_pat = 10'b0011000111;
        en_pat = 10'b0011000110;
        addr_tab = '{0, 0, 1, 2, 2, 2, 2, 3, 0, 0};
        n_en = 0; n_clr = 0; n_last = 0;
        apply_reset;
        fill_bank;
        for (int c = 0; c < 10; c++) begin
            bus.run = run_pat[c];
            #1;
            checks++;
            if ({bus.rd_en, bus.rd_addr} !== {en_pat[c], 4'(addr_tab[c])})
                begin errors++; $display("FAIL pause_c%0d: got en/addr %b/%0d expected %b/%0d", c, bus.rd_en, bus.rd_addr, en_pat[c], addr_tab[c]); end
            n_en += int'(bus.acc_en);
            n_clr += int'(bus.acc_clear);
            n_last += int'(bus.acc_last);
            cyc;
        end
        checks++;
        if (n_en != 4 || n_clr != 1 || n_last != 1)
            begin errors++; $display("FAIL pause_acc_counts: got en/clear/last %0d/%0d/%0d expected 4/1/1", n_en, n_clr, n_last); end
    endtask

    task automatic test_reuse;
        apply_reset;
        fill_bank;
        bus.reuse = 1; bus.run = 1;
        for (int c = 0; c < 11; c++) begin
            logic er;
            logic [3:0] ea;
            if (c == 10) bus.run = 0;
            er = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
            ea = (c >= 1 && c <= 4) ? 4'(c - 1) : (c >= 6 && c <= 9) ? 4'(c - 6) : 4'd0;
            #1;
            checks++;
            if ({bus.rd_en, bus.rd_addr, bus.rd_bank, bus.bank_full} !== {er, ea, 1'b0, 2'b01})
                begin errors++; $display("FAIL reuse_c%0d: got en/addr/bank/full %b/%0d/%0d/%b expected %b/%0d/0/01", c, bus.rd_en, bus.rd_addr, bus.rd_bank, bus.bank_full, er, ea); end
            cyc;
        end
        bus.reuse = 0;
    endtask

    task automatic test_flush_reset;
        apply_reset;
        bus.wr_valid = 1;
        cyc;
        cyc;
        bus.flush = 1;
        #1;
        checks++;
        if ({bus.wr_ready, bus.wr_en, bus.wr_addr} !== {1'b0, 2'b00, 4'd2})
            begin errors++; $display("FAIL flush_block: got rdy/en/addr %b/%b/%0d expected 0/00/2", bus.wr_ready, bus.wr_en, bus.wr_addr); end
        cyc;
        bus.flush = 0;
        #1;
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_bank, bus.bank_full} !== {2'b01, 4'd0, 1'b0, 2'b00})
            begin errors++; $display("FAIL flush_restart: got en/addr/bank/full %b/%0d/%0d/%b expected 01/0/0/00", bus.wr_en, bus.wr_addr, bus.wr_bank, bus.bank_full); end
        repeat (DP) cyc;
        bus.wr_valid = 0;
        bus.run = 1;
        cyc;
        cyc;
        #1;
        checks++;
        if ({bus.rd_en, bus.rd_addr, bus.acc_en, bus.bank_full} !== {1'b1, 4'd1, 1'b1, 2'b01})
            begin errors++; $display("FAIL mid_read: got en/addr/acc/full %b/%0d/%b/%b expected 1/1/1/01", bus.rd_en, bus.rd_addr, bus.acc_en, bus.bank_full); end
        reset = 1;
        #1;
        checks++;
        if ({bus.rd_en, bus.rd_addr, bus.acc_en, bus.acc_clear, bus.acc_last, bus.bank_full, bus.wr_addr} !== 13'b0)
            begin errors++; $display("FAIL async_reset: got %b expected all zero", {bus.rd_en, bus.rd_addr, bus.acc_en, bus.acc_clear, bus.acc_last, bus.bank_full, bus.wr_addr}); end
        cyc;
        reset = 0;
        bus.run = 0;
        cyc;
        bus.wr_valid = 1;
        #1;
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_bank, bus.rd_en} !== {2'b01, 4'd0, 1'b0, 1'b0})
            begin errors++; $display("FAIL reset_restart: got en/addr/bank/rd_en %b/%0d/%0d/%b expected 01/0/0/0", bus.wr_en, bus.wr_addr, bus.wr_bank, bus.rd_en); end
        cyc;
        bus.wr_valid = 0;
    endtask

    initial begin
        test_reset;
        test_fill;
        test_read_pass;
        test_backpressure;
        test_pause;
        test_reuse;
        test_flush_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
